// File: rtl/systolic_seq_ctrl.sv
// systolic_seq_ctrl: job sequencer for the systolic array (weight preload, skewed stream, drain).
// Define SEQ_PERF_CNT_EN to add the perf_cycles per-job busy-cycle counter output.
module systolic_seq_ctrl #(
  parameter int ROW    = 4,
  parameter int COL    = 4,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic              abort,
  input  logic [4:0]        weight_dim,
  input  logic [ADDR_W-1:0] num_vectors,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              weight_en,
  output logic              conv_ctrl,
  output logic              w_rd_en,
  output logic [ADDR_W-1:0] w_rd_addr,
  output logic              f_rd_en,
  output logic [ADDR_W-1:0] f_rd_addr,
  output logic [ROW-1:0]    in_en
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [15:0]       perf_cycles
`endif
);

  localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] DR_LAST = ADDR_W'(ROW + COL - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STRM,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e            st_q, st_d;
  logic [4:0]        dim_q, dim_d;
  logic [ADDR_W-1:0] num_q, num_d;
  logic [ADDR_W-1:0] wa_q, wa_d;
  logic [ADDR_W-1:0] fa_q, fa_d;
  logic [ADDR_W-1:0] dr_q, dr_d;
  logic [ROW-1:0]    sr_q, sr_d;
  logic              err_q, err_d;
  logic              bad_cfg;
  logic              accept;
  logic              skew_run;

  assign bad_cfg = (weight_dim == 5'd0)
                || (int'(weight_dim) > ROW)
                || (num_vectors == '0);

  assign accept   = (st_q == S_IDLE) && start && !abort && !bad_cfg;
  assign skew_run = (st_q == S_STRM) || (st_q == S_DRAIN)
                 || (st_q == S_DONE);

  always_comb begin
    st_d  = st_q;
    dim_d = dim_q;
    num_d = num_q;
    wa_d  = wa_q;
    fa_d  = fa_q;
    dr_d  = dr_q;
    err_d = 1'b0;
    sr_d  = '0;
    unique case (st_q)
      S_IDLE: begin
        if (start && !abort) begin
          if (bad_cfg) begin
            err_d = 1'b1;
          end else begin
            dim_d = weight_dim;
            num_d = num_vectors;
            wa_d  = '0;
            st_d  = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (wa_q == ADDR_W'(dim_q) - ONE) begin
          fa_d = '0;
          st_d = S_STRM;
        end else begin
          wa_d = wa_q + ONE;
        end
      end
      S_STRM: begin
        if (fa_q == num_q - ONE) begin
          dr_d = '0;
          st_d = S_DRAIN;
        end else begin
          fa_d = fa_q + ONE;
        end
      end
      S_DRAIN: begin
        if (dr_q == DR_LAST) st_d = S_DONE;
        else                 dr_d = dr_q + ONE;
      end
      S_DONE:  st_d = S_IDLE;
      default: st_d = S_IDLE;
    endcase
    // Skew chain: bit 0 mirrors f_rd_en one cycle late (buffer read latency).
    if (skew_run) begin
      sr_d[0] = (st_q == S_STRM);
      for (int r = 1; r < ROW; r++) sr_d[r] = sr_q[r-1];
    end
    if (abort && st_q != S_IDLE) begin
      st_d = S_IDLE;
      wa_d = '0;
      fa_d = '0;
      dr_d = '0;
      sr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      st_q  <= S_IDLE;
      dim_q <= '0;
      num_q <= '0;
      wa_q  <= '0;
      fa_q  <= '0;
      dr_q  <= '0;
      sr_q  <= '0;
      err_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      dim_q <= dim_d;
      num_q <= num_d;
      wa_q  <= wa_d;
      fa_q  <= fa_d;
      dr_q  <= dr_d;
      sr_q  <= sr_d;
      err_q <= err_d;
    end
  end

  assign busy      = (st_q != S_IDLE);
  assign done      = (st_q == S_DONE);
  assign err       = err_q;
  assign weight_en = (st_q == S_LOAD);
  assign w_rd_en   = (st_q == S_LOAD);
  assign conv_ctrl = (st_q == S_STRM) || (st_q == S_DRAIN);
  assign f_rd_en   = (st_q == S_STRM);
  assign w_rd_addr = wa_q;
  assign f_rd_addr = fa_q;

  always_comb begin
    in_en = '0;
    for (int r = 0; r < ROW; r++) begin
      in_en[r] = sr_q[r] && (int'(dim_q) > r);
    end
  end

`ifdef SEQ_PERF_CNT_EN
  logic [15:0] run_q;
  logic [15:0] perf_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      run_q  <= '0;
      perf_q <= '0;
    end else begin
      if (accept) begin
        run_q <= '0;
      end else if (busy && run_q != 16'hFFFF) begin
        run_q <= run_q + 16'd1;
      end
      // DONE itself is a busy cycle, hence the +1 at capture.
      if (st_q == S_DONE) begin
        perf_q <= (run_q == 16'hFFFF) ? run_q : run_q + 16'd1;
      end
    end
  end

  assign perf_cycles = perf_q;
`endif

endmodule
